instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch stage of the out-of-order core. It generates the program counter, drives the enable and byte address of the synchronous instruction memory, captures the returned words one cycle later, and buffers them with their PCs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from the back end (branch mispredict, exception) flushes all buffered and in-flight fetches and restarts fetch at a new PC.

## Interface
Parameters:
- DEPTH, 4: fetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- RedirectValid  in  1  flush and restart fetch.
- RedirectPC  in  INSTRUCTION_SIZE  restart byte address; bits [1:0] are ignored and treated as 0.
- MemEN  out  1  memory read enable.
- MemAddress  out  INSTRUCTION_SIZE  byte address; the memory converts it to a word index with >>2.
- MemInstruction  in  INSTRUCTION_SIZE  memory read data, valid the cycle after a MemEN=1 edge.
- DecodeValid  out  1  queue head is valid.
- DecodeReady  in  1  decode accepts the head.
- DecodeInstruction  out  INSTRUCTION_SIZE  head instruction.
- DecodePC  out  INSTRUCTION_SIZE  head PC.

## Operation
- State:
  - PC register.
  - inflight flag plus inflight_pc.
  - Circular queue: head and tail pointers with one extra wrap bit each, and count.
- Issue condition: MemEN = !RedirectValid && (count + inflight < DEPTH). The check is conservative; a same-cycle dequeue does not add credit.
- Address: MemAddress = PC, driven combinationally from registers.
- On an edge with MemEN=1:
  - inflight <= 1, inflight_pc <= PC, PC <= PC + 4.
  - PC wraps modulo 2^32, so 32'hFFFF_FFFC goes to 32'h0.
- Capture: in any cycle with inflight=1 and RedirectValid=0, {MemInstruction, inflight_pc} is written at the tail on that edge. inflight is cleared unless a new issue happens on the same edge.
- Capture ignores MemInstruction when inflight=0, because the memory returns 0 when not enabled.
- Dequeue: a handshake (DecodeValid && DecodeReady) pops the head.
- Simultaneous enqueue and dequeue: both happen and count is unchanged. When the queue is full, the credit rule already guarantees no enqueue.
- Redirect has priority over all other events. On that edge:
  - Queue empties (pointers and count to 0).
  - inflight clears, so the returning response is dropped.
  - PC <= {RedirectPC[31:2], 2'b00}.
  - No dequeue is counted, even if DecodeReady=1.
- Back-to-back redirects: the last one wins.
- Overflow or underflow of the queue is impossible by construction; an assertion flags either.

## Timing
- Reset values (applied asynchronously while RST_N=0):
  - PC = RESET_PC, inflight = 0, count = 0.
  - DecodeValid = 0, DecodeInstruction = 0, DecodePC = 0.
  - MemEN = 0 while RST_N=0; MemAddress = RESET_PC.
- Latency: PC presented in cycle t → word on MemInstruction in t+1 → enqueued at end of t+1 → DecodeValid=1 in t+2.
- Throughput: one instruction per cycle sustained when DecodeReady is held at 1.
- Redirect in cycle r:
  - DecodeValid=0 in r+1.
  - MemEN=1 with MemAddress=RedirectPC in r+1.
  - First new instruction is visible at decode in r+3.
- Reset asserted mid-operation: everything returns to reset values immediately. After deassertion, the first fetch is from RESET_PC in the first cycle.
- DecodeInstruction and DecodePC hold stable while DecodeValid=1 and DecodeReady=0.

## Structure
- Additions to RISCV_PKG:
  - FETCH_QUEUE_DEPTH.
  - RESET_PC_DEFAULT.
  - typedef struct packed fetch_entry_t {instr, pc}.
- Existing package constants reused: INSTRUCTION_SIZE and WORD_LENGTH.
- One sub-module: fetch_queue, a parameterised synchronous FIFO of fetch_entry_t with flush, count output and async active-low reset. The top level holds the PC, the inflight tracking and the credit logic.

## Test plan
- Reset release, DecodeReady=1, memory preloaded with word[i] = 32'h1000_0000 + i → MemAddress 0 in cycle 0; decode sees PC 0 / 32'h1000_0000 in cycle 2, then PCs 4, 8, 12 on consecutive cycles.
- DecodeReady=0 from reset → exactly 4 entries are queued and MemEN drops to 0. Raising DecodeReady then drains PCs 0, 4, 8, 12 in order with none lost or duplicated.
- Queue full, then RedirectValid=1 with RedirectPC=32'h0000_0103 → DecodeValid=0 next cycle; MemAddress=32'h100 next cycle; DecodePC=32'h100 two cycles after that.
- Redirect in the same cycle a response is returning → that stale word never appears at decode, and the sequence restarts cleanly from the target.
- RESET_PC=32'hFFFF_FFF8 with streaming → decode sees PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- RST_N pulsed low mid-stream with the queue half full → DecodeValid and MemEN go to 0 at once; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTRUCTION_SIZE  = 32;
  localparam int unsigned WORD_LENGTH       = 32;
  localparam int unsigned FETCH_QUEUE_DEPTH = 4;
  localparam logic [INSTRUCTION_SIZE-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte stride between consecutive instruction words.
  localparam int unsigned INSTR_BYTES = WORD_LENGTH / 8;

  typedef struct packed {
    logic [INSTRUCTION_SIZE-1:0] instr;
    logic [INSTRUCTION_SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular FIFO of fetched {instr, pc} entries with flush and occupancy count.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output logic             valid,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W:0] head_ptr;
  logic [PTR_W:0] tail_ptr;
  fetch_entry_t   storage [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && valid && !flush;
  assign valid   = (count != '0);
  // Head reads as zero when empty so decode never sees stale payload.
  assign head    = valid ? storage[head_ptr[PTR_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + (PTR_W+1)'(1);
      if (do_pop)  head_ptr <= head_ptr + (PTR_W+1)'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[tail_ptr[PTR_W-1:0]] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !valid && !flush));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC generation, one-deep in-flight tracking, credit check, fetch queue.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  parameter logic [INSTRUCTION_SIZE-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        RedirectValid,
  input  logic [INSTRUCTION_SIZE-1:0] RedirectPC,
  output logic                        MemEN,
  output logic [INSTRUCTION_SIZE-1:0] MemAddress,
  input  logic [INSTRUCTION_SIZE-1:0] MemInstruction,
  output logic                        DecodeValid,
  input  logic                        DecodeReady,
  output logic [INSTRUCTION_SIZE-1:0] DecodeInstruction,
  output logic [INSTRUCTION_SIZE-1:0] DecodePC
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [INSTRUCTION_SIZE-1:0] pc;
  logic [INSTRUCTION_SIZE-1:0] inflight_pc;
  logic                        inflight;
  logic [CNT_W-1:0]            count;
  logic [CNT_W:0]              occupancy;
  logic                        credit;
  logic                        issue;
  logic                        capture;
  fetch_entry_t                push_data;
  fetch_entry_t                head;
  logic                        unused_redirect_lsb;

  assign unused_redirect_lsb = ^RedirectPC[1:0];

  // Conservative credit: a dequeue on the same edge does not free a slot.
  assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
  assign credit    = occupancy < (CNT_W+1)'(DEPTH);
  assign issue     = RST_N && !RedirectValid && credit;
  assign capture   = inflight && !RedirectValid;

  assign MemEN      = issue;
  assign MemAddress = pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (RedirectValid) begin
      pc       <= {RedirectPC[INSTRUCTION_SIZE-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + INSTRUCTION_SIZE'(INSTR_BYTES);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  assign push_data.instr = MemInstruction;
  assign push_data.pc    = inflight_pc;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk       (CLK),
    .rst_n     (RST_N),
    .flush     (RedirectValid),
    .push      (capture),
    .push_data (push_data),
    .pop       (DecodeValid && DecodeReady),
    .valid     (DecodeValid),
    .head      (head),
    .count     (count)
  );

  assign DecodeInstruction = head.instr;
  assign DecodePC          = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr = '0;
  logic        decode_valid;
  logic        decode_ready = 1'b0;
  logic [31:0] decode_instr;
  logic [31:0] decode_pc;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_mem_en;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_instr = '0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    int          t;
  } exp_t;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous instruction memories: data the cycle after enable, zero otherwise.
  always @(posedge CLK) mem_instr   <= mem_en   ? word_at(mem_addr)   : 32'h0;
  always @(posedge CLK) w_mem_instr <= w_mem_en ? word_at(w_mem_addr) : 32'h0;

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .RedirectValid(redirect_valid), .RedirectPC(redirect_pc),
    .MemEN(mem_en), .MemAddress(mem_addr), .MemInstruction(mem_instr),
    .DecodeValid(decode_valid), .DecodeReady(decode_ready),
    .DecodeInstruction(decode_instr), .DecodePC(decode_pc)
  );

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .RedirectValid(w_redirect), .RedirectPC(w_redirect_pc),
    .MemEN(w_mem_en), .MemAddress(w_mem_addr), .MemInstruction(w_mem_instr),
    .DecodeValid(w_valid), .DecodeReady(w_ready),
    .DecodeInstruction(w_instr), .DecodePC(w_pc)
  );

  task automatic do_reset(input logic ready);
    @(posedge CLK); #1;
    RST_N = 1'b0; redirect_valid = 1'b0; decode_ready = ready;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge CLK); #1;
    RST_N = 1'b0; decode_ready = 1'b1; redirect_valid = 1'b0;
    #1;
    checks++; if (decode_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", decode_valid); end
    checks++; if (decode_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", decode_pc); end
    checks++; if (decode_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", decode_instr); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_memen got=%b want=0", mem_en); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    checks++; if (w_mem_addr !== WRAP_PC) begin failures++; $display("FAIL reset_wrap_addr got=%h want=%h", w_mem_addr, WRAP_PC); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    @(negedge CLK);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL stream_c0 got en=%b addr=%h want en=1 addr=0", mem_en, mem_addr); end
    @(negedge CLK);
    checks++; if (decode_valid !== 1'b0) begin failures++; $display("FAIL stream_c1_valid got=%b want=0", decode_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if (decode_valid !== 1'b1 || decode_pc !== 32'(4*k) || decode_instr !== 32'h1000_0000 + 32'(k)) begin
        failures++;
        $display("FAIL stream_word%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, decode_valid, decode_pc, decode_instr, 32'(4*k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_fill_drain;
    int issued = 0;
    do_reset(1'b0);
    repeat (8) begin
      @(negedge CLK);
      if (mem_en === 1'b1) issued++;
    end
    checks++; if (issued != 4) begin failures++; $display("FAIL fill_issued got=%0d want=4", issued); end
    checks++; if (mem_en !== 1'b0 || decode_valid !== 1'b1 || decode_pc !== 32'h0) begin failures++; $display("FAIL fill_state got en=%b v=%b pc=%h want en=0 v=1 pc=0", mem_en, decode_valid, decode_pc); end
    @(posedge CLK); #1 decode_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if (decode_valid !== 1'b1 || decode_pc !== 32'(4*k) || decode_instr !== word_at(32'(4*k))) begin
        failures++;
        $display("FAIL drain_word%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, decode_valid, decode_pc, decode_instr, 32'(4*k), word_at(32'(4*k)));
      end
    end
  endtask

  task automatic test_redirect_full;
    do_reset(1'b0);
    repeat (8) @(negedge CLK);
    @(posedge CLK); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge CLK);
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL redir_r_memen got=%b want=0", mem_en); end
    @(posedge CLK); #1 redirect_valid = 1'b0;
    @(negedge CLK);
    checks++; if (decode_valid !== 1'b0) begin failures++; $display("FAIL redir_r1_valid got=%b want=0", decode_valid); end
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL redir_r1_fetch got en=%b addr=%h want en=1 addr=100", mem_en, mem_addr); end
    @(negedge CLK);
    checks++; if (decode_valid !== 1'b0) begin failures++; $display("FAIL redir_r2_valid got=%b want=0", decode_valid); end
    @(negedge CLK);
    checks++; if (decode_valid !== 1'b1 || decode_pc !== 32'h100 || decode_instr !== word_at(32'h100)) begin failures++; $display("FAIL redir_r3 got v=%b pc=%h i=%h want v=1 pc=100 i=%h", decode_valid, decode_pc, decode_instr, word_at(32'h100)); end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1);
    repeat (4) @(negedge CLK);
    // Redirect while a response is returning, then a second one that must win.
    @(posedge CLK); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    @(posedge CLK); #1 redirect_pc = 32'h0000_3006;
    @(posedge CLK); #1 redirect_valid = 1'b0;
    @(negedge CLK);
    checks++; if (mem_addr !== 32'h3004 || decode_valid !== 1'b0) begin failures++; $display("FAIL b2b_r1 got addr=%h v=%b want addr=3004 v=0", mem_addr, decode_valid); end
    @(negedge CLK);
    checks++; if (decode_valid !== 1'b0) begin failures++; $display("FAIL b2b_r2_valid got=%b want=0", decode_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (decode_valid !== 1'b1 || decode_pc !== 32'h3004 + 32'(4*k) || decode_instr !== word_at(32'h3004 + 32'(4*k))) begin
        failures++;
        $display("FAIL b2b_word%0d got v=%b pc=%h i=%h want v=1 pc=%h", k, decode_valid, decode_pc, decode_instr, 32'h3004 + 32'(4*k));
      end
    end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    do_reset(1'b1);
    @(negedge CLK);
    checks++; if (w_mem_en !== 1'b1 || w_mem_addr !== WRAP_PC) begin failures++; $display("FAIL wrap_c0 got en=%b addr=%h want en=1 addr=%h", w_mem_en, w_mem_addr, WRAP_PC); end
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (w_valid !== 1'b1 || w_pc !== want[k] || w_instr !== word_at(want[k])) begin
        failures++;
        $display("FAIL wrap_word%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, w_valid, w_pc, w_instr, want[k], word_at(want[k]));
      end
    end
  endtask

  task automatic test_reset_midstream;
    do_reset(1'b1);
    repeat (5) @(negedge CLK);
    @(posedge CLK); #1 decode_ready = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1 RST_N = 1'b0;
    #1;
    checks++; if (decode_valid !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL midreset_now got v=%b en=%b want 0 0", decode_valid, mem_en); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL midreset_addr got=%h want=0", mem_addr); end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1; decode_ready = 1'b1;
    @(negedge CLK);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL midreset_c0 got en=%b addr=%h want en=1 addr=0", mem_en, mem_addr); end
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (decode_valid !== 1'b1 || decode_pc !== 32'h0) begin failures++; $display("FAIL midreset_c2 got v=%b pc=%h want v=1 pc=0", decode_valid, decode_pc); end
  endtask

  // Randomized traffic: model holds every live fetch with the cycle it may first reach decode.
  task automatic test_random;
    exp_t        q[$];
    logic [31:0] issue_pc = 32'h0;
    logic        exp_en;
    logic        exp_valid;
    int          cyc = 0;
    do_reset(1'b0);
    repeat (1500) begin
      decode_ready   = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      @(negedge CLK);
      exp_en    = !redirect_valid && (q.size() < DEPTH);
      exp_valid = (q.size() > 0) && (q[0].t <= cyc);
      checks++; if (mem_en !== exp_en) begin failures++; $display("FAIL rnd_memen cyc=%0d got=%b want=%b", cyc, mem_en, exp_en); end
      checks++; if (mem_addr !== issue_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, mem_addr, issue_pc); end
      checks++; if (decode_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, decode_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (decode_pc !== q[0].pc || decode_instr !== word_at(q[0].pc)) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d got pc=%h i=%h want pc=%h i=%h", cyc, decode_pc, decode_instr, q[0].pc, word_at(q[0].pc));
        end
      end
      if (redirect_valid) begin
        q.delete();
        issue_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_valid && decode_ready) void'(q.pop_front());
        if (exp_en) begin
          q.push_back('{pc: issue_pc, t: cyc + 2});
          issue_pc = issue_pc + 32'd4;
        end
      end
      cyc++;
      @(posedge CLK); #1;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect_full();
    test_back_to_back();
    test_pc_wrap();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
